// File: rtl/bhand_rr_arb_pkg.sv
// rtl/bhand_rr_arb_pkg.sv - arbiter state encoding and round-robin index helper
package bhand_rr_arb_pkg;

  localparam int MAX_N = 16;
  localparam int IDX_W = 4;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_t;

  // First set bit of vld scanning ptr+1, ptr+2, ... modulo n; returns ptr if none is set.
  function automatic logic [IDX_W-1:0] rr_next(input logic [MAX_N-1:0] vld,
                                               input logic [IDX_W-1:0] ptr,
                                               input int n);
    logic [IDX_W-1:0] idx;
    logic             found;
    rr_next = ptr;
    found   = 1'b0;
    for (int k = 1; k <= MAX_N; k++) begin
      idx = IDX_W'((32'(ptr) + 32'(k)) % 32'(n));
      if (k <= n && !found && vld[idx]) begin
        rr_next = idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/bhand.sv
// rtl/bhand.sv - two-entry buffered handshake (skid) stage with registered output
module bhand #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] idata,
  input  logic                  idata_vld,
  output logic                  idata_rdy,
  output logic [DATA_WIDTH-1:0] odata,
  output logic                  odata_vld,
  input  logic                  odata_rdy
);

  logic [DATA_WIDTH-1:0] skid_data;
  logic                  skid_vld;

  // Ready is registered: it only drops once the skid slot holds a stalled beat.
  assign idata_rdy = !skid_vld;

  always_ff @(posedge clk) begin
    if (rst) begin
      odata     <= '0;
      odata_vld <= 1'b0;
      skid_data <= '0;
      skid_vld  <= 1'b0;
    end else if (odata_rdy || !odata_vld) begin
      if (skid_vld) begin
        odata     <= skid_data;
        odata_vld <= 1'b1;
        skid_vld  <= 1'b0;
      end else begin
        odata_vld <= idata_vld;
        if (idata_vld) begin
          odata <= idata;
        end
      end
    end else if (idata_vld && !skid_vld) begin
      skid_data <= idata;
      skid_vld  <= 1'b1;
    end
  end

endmodule

// File: rtl/bhand_rr_arb.sv
// rtl/bhand_rr_arb.sv - packet-locked round-robin arbiter feeding a bhand output stage
module bhand_rr_arb #(
  parameter int DATA_WIDTH = 8,
  parameter int N_IN       = 4,
  parameter int SEL_WIDTH  = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_IN*DATA_WIDTH-1:0] idata,
  input  logic [N_IN-1:0]            idata_last,
  input  logic [N_IN-1:0]            idata_vld,
  output logic [N_IN-1:0]            idata_rdy,
  output logic [DATA_WIDTH-1:0]      odata,
  output logic                       odata_last,
  output logic [SEL_WIDTH-1:0]       odata_sel,
  output logic                       odata_vld,
  input  logic                       odata_rdy
);
  import bhand_rr_arb_pkg::*;

  localparam int BUF_WIDTH = DATA_WIDTH + 1 + SEL_WIDTH;

  arb_state_t             state, state_next;
  logic [SEL_WIDTH-1:0]   grant, grant_next;
  logic [SEL_WIDTH-1:0]   ptr, ptr_next;
  logic [MAX_N-1:0]       vld_ext;
  logic [DATA_WIDTH-1:0]  gnt_data;
  logic [BUF_WIDTH-1:0]   buf_idata, buf_odata;
  logic                   buf_ivld, buf_irdy;

  always_comb begin
    vld_ext = '0;
    vld_ext[N_IN-1:0] = idata_vld;
  end

  assign gnt_data  = idata[grant*DATA_WIDTH +: DATA_WIDTH];
  assign buf_idata = {idata_last[grant], grant, gnt_data};

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      grant <= '0;
      ptr   <= SEL_WIDTH'(N_IN - 1);
    end else begin
      state <= state_next;
      grant <= grant_next;
      ptr   <= ptr_next;
    end
  end

  // Arbitration happens only in IDLE, so the grant is frozen for the whole packet.
  always_comb begin
    state_next = state;
    grant_next = grant;
    ptr_next   = ptr;
    idata_rdy  = '0;
    buf_ivld   = 1'b0;
    case (state)
      IDLE: begin
        if (|idata_vld) begin
          grant_next = SEL_WIDTH'(rr_next(vld_ext, IDX_W'(ptr), N_IN));
          state_next = LOCK;
        end
      end
      LOCK: begin
        idata_rdy[grant] = buf_irdy;
        buf_ivld         = idata_vld[grant];
        if (buf_ivld && buf_irdy && idata_last[grant]) begin
          ptr_next   = grant;
          state_next = IDLE;
        end
      end
    endcase
  end

  bhand #(
    .DATA_WIDTH(BUF_WIDTH)
  ) u_bhand (
    .clk       (clk),
    .rst       (!rst),
    .idata     (buf_idata),
    .idata_vld (buf_ivld),
    .idata_rdy (buf_irdy),
    .odata     (buf_odata),
    .odata_vld (odata_vld),
    .odata_rdy (odata_rdy)
  );

  assign {odata_last, odata_sel, odata} = buf_odata;

endmodule

// File: tb/tb_bhand_rr_arb.sv
// tb/tb_bhand_rr_arb.sv - directed self-checking bench for bhand_rr_arb
module tb_bhand_rr_arb;

  localparam int DW = 8;
  localparam int NI = 4;
  localparam int SW = 2;

  logic             clk;
  logic             rst;
  logic [NI*DW-1:0] idata;
  logic [NI-1:0]    idata_last;
  logic [NI-1:0]    idata_vld;
  logic [NI-1:0]    idata_rdy;
  logic [DW-1:0]    odata;
  logic             odata_last;
  logic [SW-1:0]    odata_sel;
  logic             odata_vld;
  logic             odata_rdy;

  int checks;
  int failures;
  int cyc;
  int nout;
  int nexp;
  logic onehot_en;

  logic [7:0]    sd [NI][32];
  logic          sl [NI][32];
  int            sp [NI];
  int            sn [NI];
  logic [SW-1:0] esel  [64];
  logic [7:0]    edat  [64];
  logic          elast [64];
  int            oc    [64];

  bhand_rr_arb #(
    .DATA_WIDTH(DW),
    .N_IN      (NI),
    .SEL_WIDTH (SW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .idata      (idata),
    .idata_last (idata_last),
    .idata_vld  (idata_vld),
    .idata_rdy  (idata_rdy),
    .odata      (odata),
    .odata_last (odata_last),
    .odata_sel  (odata_sel),
    .odata_vld  (odata_vld),
    .odata_rdy  (odata_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NI; i++) begin
      if (sp[i] < sn[i]) begin
        idata_vld[i]       = 1'b1;
        idata_last[i]      = sl[i][sp[i]];
        idata[i*DW +: DW]  = sd[i][sp[i]];
      end else begin
        idata_vld[i]       = 1'b0;
        idata_last[i]      = 1'b0;
        idata[i*DW +: DW]  = '0;
      end
    end
  endtask

  task automatic load(input int i, input logic [7:0] d, input logic l);
    sd[i][sn[i]] = d;
    sl[i][sn[i]] = l;
    sn[i]++;
  endtask

  task automatic expect_beat(input logic [SW-1:0] s, input logic [7:0] d, input logic l);
    esel[nexp]  = s;
    edat[nexp]  = d;
    elast[nexp] = l;
    nexp++;
  endtask

  task automatic clear_out();
    nout = 0;
    nexp = 0;
  endtask

  // Sample mid-cycle, advance one edge, retire accepted source beats, re-drive.
  task automatic step();
    logic [NI-1:0] xf;
    logic          ox;
    #3;
    xf = idata_vld & idata_rdy;
    ox = odata_vld & odata_rdy;
    if (onehot_en) chk("rdy_onehot", 32'($countones(idata_rdy) <= 1), 32'd1);
    if (ox === 1'b1) begin
      if (nout < nexp) begin
        chk("beat_sel",  32'(odata_sel),  32'(esel[nout]));
        chk("beat_data", 32'(odata),      32'(edat[nout]));
        chk("beat_last", 32'(odata_last), 32'(elast[nout]));
        oc[nout] = cyc;
      end else begin
        chk("extra_beat", 32'(nout + 1), 32'(nexp));
      end
      nout++;
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < NI; i++) if (xf[i] === 1'b1) sp[i]++;
    drive();
    #1;
  endtask

  task automatic run_until(input int n, input int budget);
    int k;
    k = 0;
    while (nout < n && k < budget) begin
      step();
      k++;
    end
    chk("drain_count", 32'(nout), 32'(n));
  endtask

  initial begin
    checks = 0; failures = 0; cyc = 0; nout = 0; nexp = 0;
    onehot_en = 1'b0;
    for (int i = 0; i < NI; i++) begin
      sp[i] = 0;
      sn[i] = 0;
    end
    rst = 1'b0;
    odata_rdy = 1'b1;

    // Reset with every requester holding two 3-beat packets.
    for (int i = 0; i < NI; i++)
      for (int p = 0; p < 2; p++)
        for (int b = 0; b < 3; b++)
          load(i, 8'((i + 1) * 16 + p * 4 + b), b == 2);
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < NI; i++)
        for (int b = 0; b < 3; b++)
          expect_beat(SW'(i), 8'((i + 1) * 16 + p * 4 + b), b == 2);
    drive();
    step();
    onehot_en = 1'b1;
    chk("rst_odata_vld",  32'(odata_vld),  32'd0);
    chk("rst_idata_rdy",  32'(idata_rdy),  32'd0);
    step();
    chk("rst_odata",      32'(odata),      32'd0);
    chk("rst_odata_last", 32'(odata_last), 32'd0);
    chk("rst_odata_sel",  32'(odata_sel),  32'd0);
    chk("rst_idata_rdy2", 32'(idata_rdy),  32'd0);
    rst = 1'b1;
    step();
    chk("arb_grant0_rdy", 32'(idata_rdy), 32'b0001);
    chk("arb_no_out",     32'(odata_vld), 32'd0);
    step();
    chk("first_vld",  32'(odata_vld), 32'd1);
    chk("first_sel",  32'(odata_sel), 32'd0);
    chk("first_data", 32'(odata),     32'h10);

    // Continuous 3-beat packets: one bubble between packets only.
    run_until(24, 80);
    for (int k = 1; k < 24; k++)
      chk("beat_gap", 32'(oc[k] - oc[k-1]), (k % 3 == 0) ? 32'd2 : 32'd1);

    // Single-beat packets on requesters 0 and 3 alternate.
    clear_out();
    load(0, 8'hD0, 1'b1); load(0, 8'hD1, 1'b1);
    load(3, 8'hE0, 1'b1); load(3, 8'hE1, 1'b1);
    expect_beat(2'd0, 8'hD0, 1'b1);
    expect_beat(2'd3, 8'hE0, 1'b1);
    expect_beat(2'd0, 8'hD1, 1'b1);
    expect_beat(2'd3, 8'hE1, 1'b1);
    drive();
    run_until(4, 30);

    // Grant held on requester 2 while 1 and 0 request mid-packet.
    clear_out();
    load(2, 8'hA1, 1'b0); load(2, 8'hA2, 1'b0); load(2, 8'hA3, 1'b1);
    expect_beat(2'd2, 8'hA1, 1'b0);
    expect_beat(2'd2, 8'hA2, 1'b0);
    expect_beat(2'd2, 8'hA3, 1'b1);
    expect_beat(2'd0, 8'hC1, 1'b1);
    expect_beat(2'd1, 8'hB1, 1'b1);
    drive();
    step();
    chk("lock2_rdy_a", 32'(idata_rdy), 32'b0100);
    load(1, 8'hB1, 1'b1);
    load(0, 8'hC1, 1'b1);
    drive();
    step();
    chk("lock2_rdy_b", 32'(idata_rdy), 32'b0100);
    step();
    chk("lock2_rdy_c", 32'(idata_rdy), 32'b0100);
    step();
    chk("idle_rdy", 32'(idata_rdy), 32'b0000);
    step();
    chk("next_grant0", 32'(idata_rdy), 32'b0001);
    run_until(5, 30);

    // Backpressure on a 5-beat packet from requester 1.
    clear_out();
    for (int b = 0; b < 5; b++) begin
      load(1, 8'(8'h10 + b), b == 4);
      expect_beat(2'd1, 8'(8'h10 + b), b == 4);
    end
    odata_rdy = 1'b1;
    drive();
    step();
    chk("bp_grant1", 32'(idata_rdy), 32'b0010);
    step();
    chk("bp_rdy_e1", 32'(idata_rdy), 32'b0010);
    odata_rdy = 1'b0;
    step();
    chk("bp_full_a", 32'(idata_rdy), 32'b0000);
    chk("bp_vld",    32'(odata_vld), 32'd1);
    step();
    chk("bp_full_b", 32'(idata_rdy), 32'b0000);
    chk("bp_hold",   32'(odata),     32'h10);
    odata_rdy = 1'b1;
    step();
    chk("bp_rdy_back", 32'(idata_rdy), 32'b0010);
    run_until(5, 30);
    repeat (3) step();
    chk("bp_no_dup", 32'(nout), 32'd5);

    // Reset during beat 2 of a 4-beat packet.
    clear_out();
    for (int b = 0; b < 4; b++) load(2, 8'(8'h60 + b), b == 3);
    expect_beat(2'd2, 8'h60, 1'b0);
    expect_beat(2'd0, 8'h70, 1'b1);
    expect_beat(2'd2, 8'h72, 1'b1);
    drive();
    step();
    step();
    rst = 1'b0;
    step();
    chk("mid_rst_vld", 32'(odata_vld), 32'd0);
    chk("mid_rst_rdy", 32'(idata_rdy), 32'd0);
    rst = 1'b1;
    for (int i = 0; i < NI; i++) begin
      sp[i] = 0;
      sn[i] = 0;
    end
    load(0, 8'h70, 1'b1);
    load(2, 8'h72, 1'b1);
    drive();
    step();
    chk("post_rst_grant0", 32'(idata_rdy), 32'b0001);
    run_until(3, 30);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
